// File: rtl/wb_byte_bridge.sv
// Byte-stream command decoder driving single Wishbone read/write cycles.
// Responses (status and read data) are returned on an 8-bit valid/ready stream.
module wb_byte_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,  // must be >= 9
  parameter int unsigned TIMEOUT    = 1024 // must be >= 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_mosi,
  input  logic [31:0]           wb_miso,
  input  logic                  wb_ack,
  input  logic                  wb_err
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpRead  = 8'h02;
  localparam logic [7:0] RspErr  = 8'hEE;
  localparam logic [7:0] RspBad  = 8'hFF;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e                r_state;
  logic                  r_rx_ready;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;
  logic                  r_cyc;
  logic                  r_we;
  logic                  r_is_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_mosi;
  logic [31:0]           r_rdata;
  logic [2:0]            r_cnt;
  logic [TW-1:0]         r_tmo;

  logic w_rx_fire;
  logic w_tx_fire;

  assign w_rx_fire = rx_valid & r_rx_ready;
  assign w_tx_fire = r_tx_valid & tx_ready;

  assign rx_ready = r_rx_ready;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_cyc;
  assign wb_we    = r_we;
  assign wb_adr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign wb_mosi  = r_mosi;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= StIdle;
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_mosi     <= 32'h0;
      r_rdata    <= 32'h0;
      r_cnt      <= 3'd0;
      r_tmo      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rx_fire) begin
            r_is_write <= (rx_data == OpWrite);
            r_cnt      <= 3'd0;
            if (rx_data == OpWrite || rx_data == OpRead) begin
              r_state <= StAddr;
            end else begin
              r_state    <= StResp;
              r_rx_ready <= 1'b0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= RspBad;
            end
          end else begin
            r_rx_ready <= 1'b1;
          end
        end

        StAddr: begin
          if (w_rx_fire) begin
            r_addr <= {r_addr[ADDR_WIDTH-9:0], rx_data};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd3) begin
              r_cnt <= 3'd0;
              if (r_is_write) begin
                r_state <= StData;
              end else begin
                r_state    <= StBus;
                r_rx_ready <= 1'b0;
                r_cyc      <= 1'b1;
                r_we       <= 1'b0;
                r_tmo      <= '0;
              end
            end
          end
        end

        StData: begin
          if (w_rx_fire) begin
            r_mosi <= {r_mosi[23:0], rx_data};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd3) begin
              r_cnt      <= 3'd0;
              r_state    <= StBus;
              r_rx_ready <= 1'b0;
              r_cyc      <= 1'b1;
              r_we       <= 1'b1;
              r_tmo      <= '0;
            end
          end
        end

        StBus: begin
          r_tmo <= r_tmo + 1'b1;
          // err wins over a simultaneous ack
          if (wb_err || (!wb_ack && r_tmo == TmoLast)) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_state    <= StResp;
            r_tx_valid <= 1'b1;
            r_tx_data  <= RspErr;
            r_cnt      <= 3'd0;
          end else if (wb_ack) begin
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_state    <= StResp;
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_is_write ? OpWrite : OpRead;
            r_cnt      <= r_is_write ? 3'd0 : 3'd4;
            r_rdata    <= wb_miso;
          end
        end

        StResp: begin
          // r_cnt holds the number of bytes still to follow the current one
          if (w_tx_fire) begin
            if (r_cnt == 3'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= StIdle;
              r_rx_ready <= 1'b1;
            end else begin
              r_tx_data <= r_rdata[31:24];
              r_rdata   <= {r_rdata[23:0], 8'h00};
              r_cnt     <= r_cnt - 3'd1;
            end
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
